life_stepper: RTL and testbench
===============================

Name: life_stepper

Overview:
- Logic-side client of double_buffer: computes one Game-of-Life generation per step request.
- Reads the current generation through the logic read port and writes the next generation through the logic write port.
- Pulses swap when the generation is complete so that the render side sees the new frame.
- Sits between the frame/step controller and double_buffer's logic_* ports. Render-side reads are untouched.

Parameters:
- WIDTH, 64, grid columns (>=3).
- HEIGHT, 48, grid rows (>=3).
- ADDR_W, $clog2(WIDTH*HEIGHT), address width.
- DATA_W, 1, cell word width; bit 0 = alive.

Ports:
- clk_130mhz  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- step_in  in  1  request one generation; sampled only in IDLE
- logic_addr_r  out  ADDR_W  read address to double_buffer
- logic_data_r  in  DATA_W  read data; valid 1 cycle after address
- logic_addr_w  out  ADDR_W  write address
- logic_data_w  out  DATA_W  write data
- logic_wr_en  out  1  write strobe
- swap_out  out  1  one-cycle swap pulse to double_buffer swap_in
- busy_out  out  1  high from step accept through SWAP inclusive
- gen_count_out  out  16  completed generations

Behaviour:
- Addressing: addr = y*WIDTH + x. Edges wrap toroidally: x-1 at x=0 is WIDTH-1, x+1 at x=WIDTH-1 is 0, and likewise for y.
- Reset (async, rst_n_in=0): state=IDLE, x=y=0. All outputs 0: logic_addr_r, logic_addr_w, logic_data_w, logic_wr_en, swap_out, busy_out, gen_count_out. Reset asserted mid-generation aborts immediately. No further writes and no swap occur. Partial writes stay in the back buffer and are overwritten by the next full generation.
- States: IDLE, READ, WRITE, SWAP.
- IDLE:
  - If step_in=1, go to READ with x=y=0, k=0, count=0, and set busy_out=1.
  - step_in in any other state is ignored and not queued.
- READ (10 cycles per cell):
  - Cycles k=0..8 issue logic_addr_r for neighbourhood offset (dy,dx) in row-major order (-1,-1),(-1,0),…,(+1,+1). k=4 is the centre.
  - Data for k arrives at cycle k+1.
  - Off-centre data adds bit 0 to a 4-bit neighbour count. Centre data is latched as alive.
  - Cycle 9 only drains the last datum. Then go to WRITE.
- WRITE (1 cycle):
  - logic_wr_en=1 and logic_addr_w=current cell.
  - logic_data_w = {zeros, next}, where next = (count==3) | (alive & count==2).
  - Advance x. On x wrap, x=0 and y++.
  - If the last cell (WIDTH-1,HEIGHT-1) was written, go to SWAP. Otherwise go to READ with k=0, count=0.
- SWAP (1 cycle):
  - swap_out=1 and gen_count_out increments (16-bit, wraps 0xFFFF→0).
  - Next cycle: IDLE with busy_out=0 and swap_out=0.
  - A step_in in the IDLE cycle right after SWAP is accepted.
- Latency: 11 cycles per cell. Generation = 11*WIDTH*HEIGHT + 1 cycles from step accept to the swap pulse.
- Outputs are registered. logic_wr_en and swap_out are never high in the same cycle. logic_wr_en is 0 outside WRITE.
- Reads and writes target different buffers (double_buffer guarantee), so writes never affect reads of the current generation.

Test Plan:
- Reset: hold rst_n_in=0 for 5 cycles mid-READ → all outputs 0 and state IDLE. With rst_n_in=1 and step_in=0, no logic_wr_en or swap_out occurs for 100 cycles.
- Blinker (WIDTH=HEIGHT=5, model double_buffer behaviourally): horizontal cells (1,2),(2,2),(3,2) plus one step → swap_out exactly 276 cycles after accept. Back buffer holds vertical (2,1),(2,2),(2,3). A second step restores the horizontal pattern. gen_count_out=2.
- Block still life, 2x2 at (0,0) on 5x5 → unchanged after step. Exactly 25 logic_wr_en pulses, each address 0..24 written once in ascending order.
- Toroidal wrap: glider near corner (3,3) on 5x5, 20 steps → pattern equals the glider translated (+5,+5) mod 5, i.e. identical to start.
- Step while busy: pulse step_in at accept+10 and accept+200 → only one swap_out, gen_count_out=1. A step_in in the first IDLE cycle after SWAP starts a new generation.
- gen_count wrap: force gen_count to 0xFFFF and step → gen_count_out=0x0000 in the cycle after swap_out.

Source files
------------

// File: rtl/life_stepper.sv
// Game-of-Life generation engine driving the logic side of double_buffer.
// Each cell: nine neighbourhood reads, one drain cycle, one write-back.
module life_stepper #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT),
    parameter int DATA_W = 1
) (
    input  logic              clk_130mhz,
    input  logic              rst_n_in,
    input  logic              step_in,
    output logic [ADDR_W-1:0] logic_addr_r,
    input  logic [DATA_W-1:0] logic_data_r,
    output logic [ADDR_W-1:0] logic_addr_w,
    output logic [DATA_W-1:0] logic_data_w,
    output logic              logic_wr_en,
    output logic              swap_out,
    output logic              busy_out,
    output logic [15:0]       gen_count_out
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        SWAP
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    k;
    logic [3:0]    cnt;
    logic          alive;
    logic [15:0]   gen_cnt;

    logic          last_x;
    logic          last_cell;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic          datum;
    logic [3:0]    cnt_f;
    logic          nxt_alive;

    // Neighbourhood index 0..8 in row-major order, 4 is the centre cell.
    function automatic logic [ADDR_W-1:0] nb_addr(
        input logic [XW-1:0] cx,
        input logic [YW-1:0] cy,
        input logic [3:0]    idx
    );
        int dx;
        int dy;
        int nx;
        int ny;
        dy = int'(idx) / 3 - 1;
        dx = int'(idx) % 3 - 1;
        nx = int'(cx) + dx;
        ny = int'(cy) + dy;
        if (nx < 0) nx = WIDTH - 1;
        else if (nx >= WIDTH) nx = 0;
        if (ny < 0) ny = HEIGHT - 1;
        else if (ny >= HEIGHT) ny = 0;
        return ADDR_W'(ny * WIDTH + nx);
    endfunction

    assign last_x    = (x == XW'(WIDTH - 1));
    assign last_cell = last_x && (y == YW'(HEIGHT - 1));
    assign nxt_x     = last_x ? '0 : x + 1'b1;
    assign nxt_y     = last_cell ? '0 : (last_x ? y + 1'b1 : y);
    assign datum     = logic_data_r[0];
    assign cnt_f     = cnt + {3'b000, datum};
    // At k=9 cnt_f already includes the last neighbour.
    assign nxt_alive = (cnt_f == 4'd3) || (alive && cnt_f == 4'd2);

    assign gen_count_out = gen_cnt;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            k            <= '0;
            cnt          <= '0;
            alive        <= 1'b0;
            gen_cnt      <= '0;
            logic_addr_r <= '0;
            logic_addr_w <= '0;
            logic_data_w <= '0;
            logic_wr_en  <= 1'b0;
            swap_out     <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            logic_wr_en <= 1'b0;
            swap_out    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (step_in) begin
                        state        <= READ;
                        x            <= '0;
                        y            <= '0;
                        k            <= '0;
                        cnt          <= '0;
                        alive        <= 1'b0;
                        busy_out     <= 1'b1;
                        logic_addr_r <= nb_addr('0, '0, 4'd0);
                    end
                end
                READ: begin
                    // Datum for index k-1 is on the read port now.
                    if (k == 4'd5) alive <= datum;
                    else if (k != 4'd0) cnt <= cnt_f;
                    if (k < 4'd8) logic_addr_r <= nb_addr(x, y, k + 4'd1);
                    if (k == 4'd9) begin
                        state        <= WRITE;
                        logic_wr_en  <= 1'b1;
                        logic_addr_w <= nb_addr(x, y, 4'd4);
                        logic_data_w <= DATA_W'(nxt_alive);
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                WRITE: begin
                    x <= nxt_x;
                    y <= nxt_y;
                    if (last_cell) begin
                        state    <= SWAP;
                        swap_out <= 1'b1;
                    end else begin
                        state        <= READ;
                        k            <= '0;
                        cnt          <= '0;
                        alive        <= 1'b0;
                        logic_addr_r <= nb_addr(nxt_x, nxt_y, 4'd0);
                    end
                end
                SWAP: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    gen_cnt  <= gen_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper on a 5x5 torus.
// A behavioural double_buffer model supplies reads and absorbs writes.
module tb_life_stepper;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step_in = 1'b0;
    logic [AW-1:0] addr_r;
    logic [0:0]    data_r = '0;
    logic [AW-1:0] addr_w;
    logic [0:0]    data_w;
    logic          wr_en;
    logic          swap;
    logic          busy;
    logic [15:0]   gen;

    always #4 clk = ~clk;

    life_stepper #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(AW),
        .DATA_W(1)
    ) dut (
        .clk_130mhz   (clk),
        .rst_n_in     (rst_n),
        .step_in      (step_in),
        .logic_addr_r (addr_r),
        .logic_data_r (data_r),
        .logic_addr_w (addr_w),
        .logic_data_w (data_w),
        .logic_wr_en  (wr_en),
        .swap_out     (swap),
        .busy_out     (busy),
        .gen_count_out(gen)
    );

    logic mem [0:1][0:N-1];
    logic sel = 1'b0;
    int   wr_q[$];
    int   both_hi = 0;
    int   swap_cnt = 0;

    // Logic side reads front (sel), writes back (~sel); swap flips them.
    always @(posedge clk) begin
        data_r <= mem[sel][addr_r];
        if (wr_en) begin
            mem[~sel][addr_w] = data_w[0];
            wr_q.push_back(int'(addr_w));
        end
        if (wr_en && swap) both_hi++;
        if (swap) begin
            swap_cnt++;
            sel = ~sel;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [N-1:0] p);
        for (int i = 0; i < N; i++) mem[sel][i] = p[i];
    endtask

    function automatic logic [N-1:0] front();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = mem[sel][i];
        return r;
    endfunction

    task automatic wait_swap(output int lat);
        lat = 1;
        while (!swap && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (!swap) lat = -1;
    endtask

    task automatic run_step(output int lat);
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        wait_swap(lat);
        @(negedge clk);
    endtask

    localparam logic [N-1:0] BLINK_H = 25'h7 << 11;
    localparam logic [N-1:0] BLINK_V = (25'h1 << 7) | (25'h1 << 12) | (25'h1 << 17);
    localparam logic [N-1:0] BLOCK   = 25'h63;
    localparam logic [N-1:0] GLIDER  = (25'h1 << 19) | (25'h1 << 20) | (25'h1 << 3)
                                     | (25'h1 << 4) | (25'h1 << 0);
    localparam logic [N-1:0] GLIDER4 = (25'h1 << 20) | (25'h1 << 1) | (25'h1 << 9)
                                     | (25'h1 << 5) | (25'h1 << 6);

    initial begin
        int lat;
        int bad;
        int sw0;
        int act;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mem[b][i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_addr_r", 32'(addr_r), 0);
        check("rst_addr_w", 32'(addr_w), 0);
        check("rst_data_w", 32'(data_w), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_swap", 32'(swap), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gen", 32'(gen), 0);
        rst_n = 1'b1;
        @(negedge clk);

        load(BLINK_H);
        run_step(lat);
        check("blink1_lat", 32'(lat), 276);
        check("blink1_pat", 32'(front()), 32'(BLINK_V));
        check("blink1_gen", 32'(gen), 1);
        check("blink1_busy", 32'(busy), 0);
        run_step(lat);
        check("blink2_pat", 32'(front()), 32'(BLINK_H));
        check("blink2_gen", 32'(gen), 2);

        load(BLOCK);
        wr_q.delete();
        run_step(lat);
        check("block_pat", 32'(front()), 32'(BLOCK));
        check("block_wr_count", 32'(wr_q.size()), 25);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] != i) bad++;
        check("block_wr_order", 32'(bad), 0);

        load(GLIDER);
        repeat (4) run_step(lat);
        check("glider4_pat", 32'(front()), 32'(GLIDER4));
        repeat (16) run_step(lat);
        check("glider20_pat", 32'(front()), 32'(GLIDER));
        check("glider_gen", 32'(gen), 23);

        sw0 = swap_cnt;
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        lat = 1;
        while (!swap && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == 10 || lat == 200) step_in = 1'b1;
            else step_in = 1'b0;
        end
        step_in = 1'b0;
        check("busy_lat", 32'(lat), 276);
        @(negedge clk);
        check("busy_swaps", 32'(swap_cnt - sw0), 1);
        check("busy_gen", 32'(gen), 24);
        check("idle_busy", 32'(busy), 0);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        check("back2back_busy", 32'(busy), 1);
        wait_swap(lat);
        check("back2back_lat", 32'(lat), 276);
        @(negedge clk);
        check("back2back_gen", 32'(gen), 25);

        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_addr_r", 32'(addr_r), 0);
        check("midrst_addr_w", 32'(addr_w), 0);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_swap", 32'(swap), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_gen", 32'(gen), 0);
        rst_n = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_en || swap || busy) act++;
        end
        check("quiet_after_rst", 32'(act), 0);

        force dut.gen_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.gen_cnt;
        @(negedge clk);
        check("wrap_pre", 32'(gen), 32'hFFFF);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        wait_swap(lat);
        check("wrap_at_swap", 32'(gen), 32'hFFFF);
        @(negedge clk);
        check("wrap_after", 32'(gen), 0);

        check("wr_swap_overlap", 32'(both_hi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
